csr_access_unit: RTL and testbench

//   Initiator side of the machine/vector CSR register-file port. Accepts one CSR

---
 rtl/csr_access_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_csr_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit
// Initiator side of the machine/vector CSR register-file port. Takes one CSR
// instruction from execute, reads the CSR, forms the read-modify-write value,
// issues at most one write, and returns the old value (or raises an
// illegal-instruction exception instead). Only one request is in flight at a time.
module csr_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic                  req_imm,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_rs1_data,
  input  logic [4:0]            req_zimm,
  input  logic                  req_rs1_is_x0,
  input  logic [31:0]           req_pc,
  input  logic                  flush,
  output logic                  csr_read_en,
  output logic [ADDR_WIDTH-1:0] csr_read_addr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_write_en,
  output logic [ADDR_WIDTH-1:0] csr_write_addr,
  output logic [DATA_WIDTH-1:0] csr_write_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rd_data,
  input  logic                  resp_ready,
  output logic                  exc_valid,
  output logic [3:0]            exc_cause,
  output logic [31:0]           exc_pc
);

  // CSR operation encodings as they arrive from decode
  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  // Illegal-instruction cause code reported on the exception port
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    EXC   = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  state_t next_raw;

  // Request fields captured at accept time; execute is free to move on
  logic [1:0]            op_q;
  logic                  imm_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rs1_q;
  logic [4:0]            zimm_q;
  logic                  x0_q;
  logic [31:0]           pc_q;
  logic [DATA_WIDTH-1:0] old_q;

  logic                  accept;
  logic [DATA_WIDTH-1:0] src_val;
  logic                  wr_intent;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] wdata;

  // Set of CSR addresses implemented by the register file behind this port.
  // Anything not listed here is reported as an illegal instruction.
  function automatic logic csr_is_defined(input logic [ADDR_WIDTH-1:0] a);
    logic hit;
    case (a)
      // vector user CSRs
      12'h008, 12'h009, 12'h00A, 12'h00F,
      12'hC20, 12'hC21, 12'hC22:                  hit = 1'b1;
      // user counters (read-only shadows)
      12'hC00, 12'hC01, 12'hC02:                  hit = 1'b1;
      // machine information (read-only)
      12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15: hit = 1'b1;
      // machine trap setup
      12'h300, 12'h301, 12'h302, 12'h303,
      12'h304, 12'h305, 12'h306, 12'h310:         hit = 1'b1;
      // machine counter inhibit
      12'h320:                                    hit = 1'b1;
      // machine trap handling
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344: hit = 1'b1;
      // machine counters
      12'hB00, 12'hB02, 12'hB80, 12'hB82:         hit = 1'b1;
      default:                                    hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Top two address bits both set mark a read-only CSR
  function automatic logic csr_is_read_only(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1 -: 2] == 2'b11);
  endfunction

  // Read-modify-write combine of the old CSR value with the source operand
  function automatic logic [DATA_WIDTH-1:0] rmw_value(
    input logic [1:0]            op,
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] src
  );
    logic [DATA_WIDTH-1:0] res;
    case (op)
      OP_RW:   res = src;
      OP_RS:   res = old | src;
      OP_RC:   res = old & ~src;
      default: res = {DATA_WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  // A request is only taken while idle, not being flushed and not in reset
  assign accept = req_valid & req_ready;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the request on accept and the old CSR value during READ
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 2'b00;
      imm_q  <= 1'b0;
      addr_q <= {ADDR_WIDTH{1'b0}};
      rs1_q  <= {DATA_WIDTH{1'b0}};
      zimm_q <= 5'd0;
      x0_q   <= 1'b0;
      pc_q   <= 32'd0;
      old_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (accept) begin
        op_q   <= req_op;
        imm_q  <= req_imm;
        addr_q <= req_addr;
        rs1_q  <= req_rs1_data;
        zimm_q <= req_zimm;
        x0_q   <= req_rs1_is_x0;
        pc_q   <= req_pc;
      end
      if (state == READ) begin
        old_q <= csr_rdata;
      end
    end
  end

  // Source operand, write intent and legality of the latched instruction.
  // A set/clear with a zero source field (x0 or zimm 0) is a pure read, so
  // it is legal even on a read-only CSR.
  always_comb begin
    src_val   = {DATA_WIDTH{1'b0}};
    wr_intent = 1'b0;
    illegal   = 1'b0;
    wdata     = {DATA_WIDTH{1'b0}};
    if (imm_q) begin
      src_val   = {{(DATA_WIDTH-5){1'b0}}, zimm_q};
      wr_intent = (op_q == OP_RW) | (zimm_q != 5'd0);
    end else begin
      src_val   = rs1_q;
      wr_intent = (op_q == OP_RW) | ~x0_q;
    end
    illegal = (op_q == OP_ILL) | ~csr_is_defined(addr_q) |
              (wr_intent & csr_is_read_only(addr_q));
    wdata   = rmw_value(op_q, old_q, src_val);
  end

  // Next-state logic; flush overrides every state and returns to IDLE
  always_comb begin
    next_raw = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_raw = READ;
        end else begin
          next_raw = IDLE;
        end
      end
      READ: begin
        if (illegal) begin
          next_raw = EXC;
        end else if (wr_intent) begin
          next_raw = WRITE;
        end else begin
          next_raw = RESP;
        end
      end
      WRITE: next_raw = RESP;
      RESP: begin
        if (resp_ready) begin
          next_raw = IDLE;
        end else begin
          next_raw = RESP;
        end
      end
      EXC:     next_raw = IDLE;
      default: next_raw = IDLE;
    endcase
    next_state = flush ? IDLE : next_raw;
  end

  // Port outputs decoded from state; flush and reset suppress any write,
  // response or exception in the same cycle, and buses idle at zero
  always_comb begin
    req_ready      = (state == IDLE) & ~flush & ~rst;
    csr_read_en    = (state == READ) & ~rst;
    csr_read_addr  = {ADDR_WIDTH{1'b0}};
    csr_write_en   = (state == WRITE) & ~flush & ~rst;
    csr_write_addr = {ADDR_WIDTH{1'b0}};
    csr_write_data = {DATA_WIDTH{1'b0}};
    resp_valid     = (state == RESP) & ~flush & ~rst;
    resp_rd_data   = {DATA_WIDTH{1'b0}};
    exc_valid      = (state == EXC) & ~flush & ~rst;
    exc_cause      = 4'd0;
    exc_pc         = 32'd0;
    if (csr_read_en) begin
      csr_read_addr = addr_q;
    end else begin
      csr_read_addr = {ADDR_WIDTH{1'b0}};
    end
    if (csr_write_en) begin
      csr_write_addr = addr_q;
      csr_write_data = wdata;
    end else begin
      csr_write_addr = {ADDR_WIDTH{1'b0}};
      csr_write_data = {DATA_WIDTH{1'b0}};
    end
    if (resp_valid) begin
      resp_rd_data = old_q;
    end else begin
      resp_rd_data = {DATA_WIDTH{1'b0}};
    end
    if (exc_valid) begin
      exc_cause = CAUSE_ILLEGAL;
      exc_pc    = pc_q;
    end else begin
      exc_cause = 4'd0;
      exc_pc    = 32'd0;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit
// Directed bench for csr_access_unit. A small CSR array stands in for the
// register file; expected results are pushed to a scoreboard queue when a
// request is driven and popped when the unit responds or raises an exception.
module tb_csr_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_imm;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_zimm;
  logic        req_rs1_is_x0;
  logic [31:0] req_pc;
  logic        flush;
  logic        csr_read_en;
  logic [11:0] csr_read_addr;
  logic [31:0] csr_rdata;
  logic        csr_write_en;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_write_data;
  logic        resp_valid;
  logic [31:0] resp_rd_data;
  logic        resp_ready;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;

  logic [31:0] mem [0:4095];

  int vectors;
  int miscompares;

  typedef struct {
    logic        is_exc;
    logic [31:0] data;
    logic [31:0] pc;
    int          cyc;
    logic        wr;
    logic [11:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  csr_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_imm        (req_imm),
    .req_addr       (req_addr),
    .req_rs1_data   (req_rs1_data),
    .req_zimm       (req_zimm),
    .req_rs1_is_x0  (req_rs1_is_x0),
    .req_pc         (req_pc),
    .flush          (flush),
    .csr_read_en    (csr_read_en),
    .csr_read_addr  (csr_read_addr),
    .csr_rdata      (csr_rdata),
    .csr_write_en   (csr_write_en),
    .csr_write_addr (csr_write_addr),
    .csr_write_data (csr_write_data),
    .resp_valid     (resp_valid),
    .resp_rd_data   (resp_rd_data),
    .resp_ready     (resp_ready),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read port
  assign csr_rdata = csr_read_en ? mem[csr_read_addr] : 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, predict its outcome, and monitor until it retires
  task automatic run_req(input string tag, input logic [1:0] op, input logic imm,
                         input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] zimm, input logic x0, input logic [31:0] pc,
                         input logic exp_ill, input int stall);
    exp_t        e;
    exp_t        got_e;
    logic [31:0] src;
    logic [31:0] old;
    logic        wi;
    int          nwr;
    int          cyc;
    bit          done;
    src = imm ? {27'd0, zimm} : rs1;
    wi  = (op == 2'b01) || (imm ? (zimm != 5'd0) : !x0);
    old = mem[addr];
    e.is_exc = exp_ill;
    e.data   = old;
    e.pc     = pc;
    e.wr     = !exp_ill && wi;
    e.waddr  = addr;
    case (op)
      2'b01:   e.wdata = src;
      2'b10:   e.wdata = old | src;
      2'b11:   e.wdata = old & ~src;
      default: e.wdata = 32'd0;
    endcase
    e.cyc = e.wr ? 3 : 2;
    sb.push_back(e);

    @(negedge clk);
    req_valid     = 1'b1;
    req_op        = op;
    req_imm       = imm;
    req_addr      = addr;
    req_rs1_data  = rs1;
    req_zimm      = zimm;
    req_rs1_is_x0 = x0;
    req_pc        = pc;
    resp_ready    = (stall == 0);
    #1;
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);

    nwr  = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      #1;
      if (csr_write_en) begin
        nwr++;
        chk({tag, "/wr_cycle"}, 32'(cyc), 32'd2);
        chk({tag, "/wr_addr"}, 32'(csr_write_addr), 32'(e.waddr));
        chk({tag, "/wr_data"}, csr_write_data, e.wdata);
        mem[csr_write_addr] = csr_write_data;
      end
      if (resp_valid || exc_valid) begin
        got_e = sb.pop_front();
        chk({tag, "/is_exc"}, 32'(exc_valid), 32'(got_e.is_exc));
        chk({tag, "/out_cycle"}, 32'(cyc), 32'(got_e.cyc));
        if (exc_valid) begin
          chk({tag, "/exc_cause"}, 32'(exc_cause), 32'd2);
          chk({tag, "/exc_pc"}, exc_pc, got_e.pc);
        end else begin
          chk({tag, "/rd_data"}, resp_rd_data, got_e.data);
          for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            #1;
            chk({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "/hold_data"}, resp_rd_data, got_e.data);
          end
          resp_ready = 1'b1;
        end
        done = 1'b1;
      end
    end
    chk({tag, "/retired"}, 32'(done), 32'd1);
    chk({tag, "/writes"}, 32'(nwr), 32'(e.wr));

    @(negedge clk);
    #1;
    chk({tag, "/back_idle"}, {29'd0, resp_valid, exc_valid, csr_write_en}, 32'd0);
    chk({tag, "/ready_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_op        = 2'b00;
    req_imm       = 1'b0;
    req_addr      = 12'd0;
    req_rs1_data  = 32'd0;
    req_zimm      = 5'd0;
    req_rs1_is_x0 = 1'b0;
    req_pc        = 32'd0;
    flush         = 1'b0;
    resp_ready    = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h300] = 32'h0000_0008;
    mem[12'h304] = 32'h0000_0880;
    mem[12'hC20] = 32'h0000_0010;
    mem[12'h305] = 32'h0000_00FF;
    mem[12'h343] = 32'h0000_DEAD;
    mem[12'h340] = 32'h0000_0011;
    mem[12'h341] = 32'h0000_1234;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/read_en", 32'(csr_read_en), 32'd0);
    chk("rst/write_en", 32'(csr_write_en), 32'd0);
    chk("rst/write_data", csr_write_data, 32'd0);
    chk("rst/resp_valid", 32'(resp_valid), 32'd0);
    chk("rst/exc_valid", 32'(exc_valid), 32'd0);
    chk("rst/exc_cause", 32'(exc_cause), 32'd0);
    chk("rst/exc_pc", exc_pc, 32'd0);

    // Main function
    run_req("rw_mstatus", 2'b01, 1'b0, 12'h300, 32'h88, 5'd0, 1'b0, 32'h8000_0000, 1'b0, 0);
    run_req("rs_mie", 2'b10, 1'b0, 12'h304, 32'h8, 5'd0, 1'b0, 32'h8000_0004, 1'b0, 0);
    run_req("rc_mie", 2'b11, 1'b0, 12'h304, 32'h8, 5'd0, 1'b0, 32'h8000_0008, 1'b0, 0);
    run_req("rsi_vl_z0", 2'b10, 1'b1, 12'hC20, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h8000_000C, 1'b0, 0);
    run_req("rwi_vl", 2'b01, 1'b1, 12'hC20, 32'd0, 5'd3, 1'b0, 32'h8000_0010, 1'b1, 0);
    run_req("rw_7c0", 2'b01, 1'b0, 12'h7C0, 32'h5, 5'd0, 1'b0, 32'h1000_0040, 1'b1, 0);
    run_req("op00", 2'b00, 1'b0, 12'h300, 32'h5, 5'd0, 1'b0, 32'h1000_0044, 1'b1, 0);
    run_req("rs_hartid_x0", 2'b10, 1'b0, 12'hF14, 32'hFFFF, 5'd0, 1'b1, 32'h8000_0014, 1'b0, 0);
    run_req("rw_hartid", 2'b01, 1'b0, 12'hF14, 32'h1, 5'd0, 1'b1, 32'h8000_0018, 1'b1, 0);
    run_req("rci_mtvec", 2'b11, 1'b1, 12'h305, 32'd0, 5'h1F, 1'b0, 32'h8000_001C, 1'b0, 0);
    run_req("rw_mtval_stall", 2'b01, 1'b0, 12'h343, 32'hBEEF, 5'd0, 1'b0, 32'h8000_0020, 1'b0, 5);

    // flush while idle blocks acceptance
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_idle/req_ready", 32'(req_ready), 32'd0);
    flush = 1'b0;

    // flush during the WRITE cycle: no write, no response
    @(negedge clk);
    req_valid     = 1'b1;
    req_op        = 2'b01;
    req_imm       = 1'b0;
    req_addr      = 12'h340;
    req_rs1_data  = 32'hAA;
    req_rs1_is_x0 = 1'b0;
    req_pc        = 32'h8000_0024;
    resp_ready    = 1'b1;
    #1;
    chk("flush_wr/ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("flush_wr/read_en", 32'(csr_read_en), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_wr/write_en", 32'(csr_write_en), 32'd0);
    chk("flush_wr/write_data", csr_write_data, 32'd0);
    chk("flush_wr/resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_wr/ready_next", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("flush_wr/quiet", {30'd0, csr_write_en, resp_valid}, 32'd0);
    end
    run_req("post_flush_read", 2'b10, 1'b0, 12'h340, 32'd0, 5'd0, 1'b1, 32'h8000_0028, 1'b0, 0);

    // reset asserted during READ: back to IDLE, nothing issued
    @(negedge clk);
    req_valid     = 1'b1;
    req_op        = 2'b01;
    req_imm       = 1'b0;
    req_addr      = 12'h341;
    req_rs1_data  = 32'h55;
    req_rs1_is_x0 = 1'b0;
    req_pc        = 32'h8000_002C;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("rst_mid/read_addr", 32'(csr_read_addr), 32'h341);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid/ready", 32'(req_ready), 32'd1);
    chk("rst_mid/read_en", 32'(csr_read_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rst_mid/quiet", {29'd0, csr_write_en, resp_valid, exc_valid}, 32'd0);
    end
    run_req("post_rst_rw", 2'b01, 1'b0, 12'h341, 32'h55, 5'd0, 1'b0, 32'h8000_0030, 1'b0, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
